// File: rtl/apb_arb_pkg.sv
// Shared constants for the APB transfer arbiter slice.
// Optional watchdog build macro: APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/apb_xfer_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Purely combinational; grant is one-hot, idx is its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest offset back so the nearest hit wins
  always_comb begin
    int i;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    i     = 0;
    for (int off = N - 1; off >= 0; off--) begin
      i = int'(ptr) + off;
      if (i >= N) i = i - N;
      if (req[i]) begin
        grant = N'(1) << i;
        idx   = IW'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_xfer_arbiter.sv
// Round-robin sequencer sharing one APB master command port.
// Optional BUSY watchdog enabled by macro APB_ARB_TIMEOUT_EN.
module apb_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      transfer,
  output logic                      pwrite_in,
  output logic [ADDR_W-1:0]         paddr_in,
  output logic [DATA_W-1:0]         pwdata_in,
  input  logic                      xfer_done,
  input  logic [DATA_W-1:0]         read_data_out
);

  import apb_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("apb_xfer_arbiter: unsupported parameters");
  end

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   g_q;
  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_wdata;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               to_hit;
  logic               err_w;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  assign to_hit = (state == ST_BUSY) &&
                  (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_w  = err_q;

  // Watchdog: counts BUSY cycles from 0, flags a missing xfer_done
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else if (state == ST_IDLE) begin
      to_cnt <= '0;
      if (pick_any) err_q <= 1'b0;
    end else if (state == ST_BUSY) begin
      to_cnt <= to_cnt + 1'b1;
      if (!xfer_done && to_hit) err_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err_w  = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: accept, wait for completion, one response cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (pick_any) state_nxt = ST_BUSY;
      ST_BUSY: if (xfer_done || to_hit) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command capture, read data capture and rotation pointer
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rr_ptr    <= '0;
      g_q       <= '0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            g_q       <= pick_idx;
            cmd_write <= req_write[pick_idx];
            cmd_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            cmd_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
            rdata_q   <= '0;
          end
        end
        ST_BUSY: begin
          if (xfer_done)
            rdata_q <= cmd_write ? '0 : read_data_out;
        end
        ST_RESP: rr_ptr <= IDX_W'(wrap_inc(int'(g_q), NUM_REQ));
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; all zero outside their own state
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    transfer  = 1'b0;
    pwrite_in = 1'b0;
    paddr_in  = '0;
    pwdata_in = '0;
    unique case (1'b1)
      (state == ST_IDLE): begin
        req_ready = presetn ? pick_grant : '0;
      end
      (state == ST_BUSY): begin
        transfer  = 1'b1;
        pwrite_in = cmd_write;
        paddr_in  = cmd_addr;
        pwdata_in = cmd_wdata;
      end
      (state == ST_RESP): begin
        rsp_valid = NUM_REQ'(1) << g_q;
        rsp_rdata = rdata_q;
        rsp_err   = err_w;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_xfer_arbiter.sv
// Scoreboard bench for apb_xfer_arbiter with an APB slave model.
// Watchdog scenario runs when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_xfer_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          transfer;
  logic          pwrite_in;
  logic [AW-1:0] paddr_in;
  logic [DW-1:0] pwdata_in;
  logic          xfer_done;
  logic [DW-1:0] read_data_out;

  apb_xfer_arbiter #(
    .NUM_REQ        (N),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .transfer      (transfer),
    .pwrite_in     (pwrite_in),
    .paddr_in      (paddr_in),
    .pwdata_in     (pwdata_in),
    .xfer_done     (xfer_done),
    .read_data_out (read_data_out)
  );

  always #5 pclk = ~pclk;

  logic [AW-1:0] cmd_a [N];
  logic [DW-1:0] cmd_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = cmd_a[i];
      req_wdata[i*DW +: DW] = cmd_d[i];
    end
  end

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ref_mem   [256];
  logic [DW-1:0] slave_mem [256];

  int            ptr_m = 0;
  bit            outstanding = 0;
  bit            clr_pend = 0;
  bit            expect_to = 0;
  bit            master_en = 1;
  bit            spurious_en = 0;
  int            fixed_delay = -1;
  int            pend_drop = -1;
  logic          cur_w;
  logic [AW-1:0] cur_a;
  logic [DW-1:0] cur_d;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t",
               name, got, exp, $time);
    end
  endfunction

  // Spec rule: first valid requester at or after the pointer
  function automatic int predict();
    for (int off = 0; off < N; off++) begin
      int i;
      i = (ptr_m + off) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic void accept(int g);
    exp_t e;
    e.id = g;
    e.err = 1'b0;
    e.rdata = '0;
    if (expect_to) begin
      e.err = 1'b1;
    end else if (req_write[g]) begin
      ref_mem[cmd_a[g]] = cmd_d[g];
    end else begin
      e.rdata = ref_mem[cmd_a[g]];
    end
    sb.push_back(e);
    cur_w = req_write[g];
    cur_a = cmd_a[g];
    cur_d = req_write[g] ? cmd_d[g] : cmd_d[g];
    outstanding = 1;
    ptr_m = (g + 1) % N;
    grant_log.push_back(g);
    pend_drop = g;
  endfunction

  task automatic tick();
    @(negedge pclk);
    #1;
    if (pend_drop >= 0) begin
      req_valid[pend_drop] = 1'b0;
      pend_drop = -1;
    end
  endtask

  task automatic sample();
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = outstanding ? -1 : predict();
    exp_rdy = (g < 0) ? '0 : N'(1) << g;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) accept(g);
  endtask

  task automatic new_cmd(int i, bit w);
    cmd_a[i]     = AW'($urandom_range(0, 15));
    cmd_d[i]     = DW'($urandom);
    req_write[i] = w;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(int budget);
    for (int k = 0; k < budget; k++) begin
      if (!outstanding && sb.size() == 0) break;
      tick();
      sample();
    end
    chk("drain", 32'(outstanding) + 32'(sb.size()), 0);
  endtask

  task automatic model_reset();
    outstanding = 0;
    clr_pend = 0;
    sb.delete();
    ptr_m = 0;
    pend_drop = -1;
    req_valid = '0;
  endtask

  // APB master/slave model: completes after a delay, keeps memory
  initial begin
    bit in_x;
    int cnt;
    in_x = 0;
    cnt = 0;
    xfer_done = 1'b0;
    read_data_out = '0;
    forever begin
      @(negedge pclk);
      xfer_done = 1'b0;
      read_data_out = DW'($urandom);
      if (!transfer) begin
        in_x = 0;
        if (master_en && spurious_en && $urandom_range(0, 7) == 0)
          xfer_done = 1'b1;
      end else if (master_en) begin
        if (!in_x) begin
          in_x = 1;
          cnt = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
        end
        if (cnt == 0) begin
          xfer_done = 1'b1;
          read_data_out = slave_mem[paddr_in];
          if (pwrite_in) slave_mem[paddr_in] = pwdata_in;
        end
        cnt--;
      end
    end
  end

  // Monitor: pops expected responses, checks master-port pins
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        chk("rst_outputs",
            {req_ready, rsp_valid, rsp_rdata, 7'd0, rsp_err},
            0);
        chk("rst_master_port",
            {7'd0, transfer, 7'd0, pwrite_in, paddr_in, pwdata_in},
            0);
      end else begin
        if (clr_pend) begin
          outstanding = 0;
          clr_pend = 0;
        end
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 0);
          end else begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(N'(1) << e.id));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
          chk("transfer_in_resp", 32'(transfer), 0);
          clr_pend = 1;
        end else begin
          chk("rsp_idle_zero", {23'd0, rsp_err, rsp_rdata}, 0);
          if (outstanding) begin
            chk("transfer", 32'(transfer), 1);
            chk("pwrite_in", 32'(pwrite_in), 32'(cur_w));
            chk("paddr_in", 32'(paddr_in), 32'(cur_a));
            if (cur_w) chk("pwdata_in", 32'(pwdata_in), 32'(cur_d));
          end else begin
            chk("port_idle_zero",
                {7'd0, transfer, 7'd0, pwrite_in, paddr_in, pwdata_in},
                0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    req_valid = '0;
    req_write = '0;
    for (int i = 0; i < N; i++) begin
      cmd_a[i] = '0;
      cmd_d[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = '0;
      slave_mem[i] = '0;
    end

    // Reset for two cycles, then idle with nothing requested
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    #1 presetn = 1'b1;
    repeat (3) begin
      tick();
      sample();
    end

    // Requester 0 writes 0x05 <- 0xAA, completion 2 cycles in
    fixed_delay = 2;
    tick();
    cmd_a[0] = 8'h05;
    cmd_d[0] = 8'hAA;
    req_write[0] = 1'b1;
    req_valid[0] = 1'b1;
    sample();
    chk("accept_req0", 32'(grant_log.size()), 1);
    wait_idle(20);

    // Requester 2 reads 0x05 back
    tick();
    cmd_a[2] = 8'h05;
    cmd_d[2] = 8'h00;
    req_write[2] = 1'b0;
    req_valid[2] = 1'b1;
    sample();
    wait_idle(20);

    // Reset asserted mid-BUSY aborts the command
    fixed_delay = 10;
    tick();
    new_cmd(3, 1'b0);
    sample();
    tick();
    chk("busy_before_rst", 32'(transfer), 1);
    presetn = 1'b0;
    #1;
    chk("transfer_async_rst", 32'(transfer), 0);
    model_reset();
    repeat (2) @(negedge pclk);
    #1 presetn = 1'b1;

    // All requesters valid: strict rotation from pointer 0
    fixed_delay = -1;
    grant_log.delete();
    for (int k = 0; k < 100 && grant_log.size() < 8; k++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) new_cmd(i, 1'($urandom_range(0, 1)));
      sample();
    end
    chk("rotation_count", 32'(grant_log.size()), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++)
      chk("rotation_order", 32'(grant_log[k]), 32'(k % N));
    tick();
    req_valid = '0;
    wait_idle(20);

    // Random traffic with spurious xfer_done outside BUSY
    spurious_en = 1;
    for (int k = 0; k < 400; k++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          new_cmd(i, 1'($urandom_range(0, 1)));
      sample();
    end
    tick();
    req_valid = '0;
    wait_idle(20);
    spurious_en = 0;

`ifdef APB_ARB_TIMEOUT_EN
    // Master never completes: watchdog ends the command
    master_en = 0;
    expect_to = 1;
    tick();
    new_cmd(1, 1'b0);
    sample();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      sample();
      if (transfer) cnt++;
      else break;
    end
    chk("timeout_busy_cycles", 32'(cnt), 16);
    wait_idle(20);
    master_en = 1;
    expect_to = 0;
`endif

    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
